// File: rtl/xoroshiro_multi_if.sv
// -----------------------------------------------------------------------------
// xoroshiro_multi_if
// Bytepipe link between the USB byte stream and the multi-channel PRNG block.
//
// Signals (names as seen from the PRNG block):
//   i_bp_data  [7:0]  host-to-block byte
//   i_bp_valid        host byte valid
//   o_bp_ready        block accepts host byte
//   o_bp_data  [7:0]  response byte
//   o_bp_valid        response valid
//   i_bp_ready        host accepts response
//
// Modports:
//   slave  - the PRNG block
//   master - the host side (bridge or testbench)
// -----------------------------------------------------------------------------
interface xoroshiro_multi_if;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;
  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready;

  modport slave (
    input  i_bp_data,
    input  i_bp_valid,
    input  i_bp_ready,
    output o_bp_ready,
    output o_bp_data,
    output o_bp_valid
  );

  modport master (
    output i_bp_data,
    output i_bp_valid,
    output i_bp_ready,
    input  o_bp_ready,
    input  o_bp_data,
    input  o_bp_valid
  );
endinterface

// File: rtl/xoroshiro_multi.sv
// -----------------------------------------------------------------------------
// xoroshiro_multi
// N_CH independent xoroshiro128+ generators behind one bytepipe register
// interface. Each channel has a run enable, can be seeded one byte at a time
// and can have its full 128-bit state read back. Read and write bursts are
// supported through the BURST register.
//
// Parameters:
//   N_CH    number of PRNG channels (1..8)
//   ADDR_W  command address width (7; command bit 7 is the write flag)
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_cg    clock gate; FSM, registers and all channels hold while low
//   bp      bytepipe (slave modport of xoroshiro_multi_if)
//
// Register map (SEL = CHSEL):
//   0x00 BURST   W   repeat count for the next non-zero-address command
//   0x01 CHSEL   R/W selected channel; values >= N_CH are ignored
//   0x02 SEED    W   shift byte into SEL state: {s1,s0} <= {s1s0[119:0], byte}
//   0x03 RESULT  R   byte BYTESEL of SEL's 64-bit result
//   0x04 XORALL  R   XOR of all channels' result[63:56] (optional)
//   0x05 ENMASK  R/W per-channel run enable
//   0x06 BYTESEL R/W 3-bit result byte select
//   0x10-0x1F    R   byte addr[3:0] of SEL {s1,s0}
//
// Build option:
//   XOROSHIRO_MULTI_XORALL_EN  when defined, 0x04 returns the XOR of all
//                              channel top bytes; otherwise 0x04 reads 0.
// -----------------------------------------------------------------------------
module xoroshiro_multi #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  xoroshiro_multi_if.slave    bp
);

  localparam logic [ADDR_W-1:0] A_BURST   = ADDR_W'(7'h00);
  localparam logic [ADDR_W-1:0] A_CHSEL   = ADDR_W'(7'h01);
  localparam logic [ADDR_W-1:0] A_SEED    = ADDR_W'(7'h02);
  localparam logic [ADDR_W-1:0] A_RESULT  = ADDR_W'(7'h03);
  localparam logic [ADDR_W-1:0] A_XORALL  = ADDR_W'(7'h04);
  localparam logic [ADDR_W-1:0] A_ENMASK  = ADDR_W'(7'h05);
  localparam logic [ADDR_W-1:0] A_BYTESEL = ADDR_W'(7'h06);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wr_q,      wr_d;
  logic [7:0]        burst_q,   burst_d;   // count armed by a BURST write
  logic [7:0]        cnt_q,     cnt_d;     // remaining repeats of the live command
  logic [2:0]        chsel_q,   chsel_d;
  logic [N_CH-1:0]   enmask_q,  enmask_d;
  logic [2:0]        bytesel_q, bytesel_d;
  logic [7:0]        data_q,    data_d;
  logic              valid_q,   valid_d;

  logic              seed_we;
  logic              host_fire;
  logic              resp_fire;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_val;
  logic [7:0]        enmask_ext;
  logic [127:0]      st_sel;
  logic [63:0]       res_sel;
  logic [127:0]      st_w [N_CH];

  // ---------------------------------------------------------------------------
  // PRNG channels. Seeding wins over stepping in the same cycle, so a running
  // channel can be reseeded without first being disabled.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [127:0] st_q;
    logic [63:0]  s0, s1x, s0n, s1n;

    assign s0  = st_q[63:0];
    assign s1x = st_q[127:64] ^ st_q[63:0];
    assign s0n = {s0[39:0], s0[63:40]} ^ s1x ^ (s1x << 16);   // rotl(s0,24) ^ s1 ^ (s1<<16)
    assign s1n = {s1x[26:0], s1x[63:27]};                     // rotl(s1,37)

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        // Fixed non-zero seed with the channel index folded in so channels
        // start on different sequences.
        st_q <= {64'hBF58_476D_1CE4_E5B9 ^ 64'(gi), 64'h9E37_79B9_7F4A_7C15 ^ 64'(gi)};
      end else if (i_cg) begin
        if (seed_we && chsel_q == 3'(gi)) begin
          st_q <= {st_q[119:0], bp.i_bp_data};
        end else if (enmask_q[gi]) begin
          st_q <= {s1n, s0n};
        end
      end
    end

    assign st_w[gi] = st_q;
  end

  // Selected-channel state, chosen by compare so the select width never has to
  // match the channel count.
  always_comb begin
    st_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (chsel_q == 3'(c)) st_sel = st_w[c];
    end
  end

  assign res_sel = st_sel[63:0] + st_sel[127:64];

`ifdef XOROSHIRO_MULTI_XORALL_EN
  logic [7:0] xor_all;
  always_comb begin
    xor_all = '0;
    for (int c = 0; c < N_CH; c++) begin
      xor_all = xor_all ^ ((st_w[c][63:0] + st_w[c][127:64]) >> 56);
    end
  end
`endif

  always_comb begin
    enmask_ext = '0;
    enmask_ext[N_CH-1:0] = enmask_q;
  end

  // ---------------------------------------------------------------------------
  // Register read mux. One mux serves the read command, each burst repeat and
  // the "old value" response of a write.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    if (rd_addr[6:4] == 3'b001) begin
      rd_val = st_sel[{rd_addr[3:0], 3'b000} +: 8];
    end else begin
      case (rd_addr)
        A_CHSEL:   rd_val = {5'b0, chsel_q};
        A_RESULT:  rd_val = res_sel[{bytesel_q, 3'b000} +: 8];
`ifdef XOROSHIRO_MULTI_XORALL_EN
        A_XORALL:  rd_val = xor_all;
`endif
        A_ENMASK:  rd_val = enmask_ext;
        A_BYTESEL: rd_val = {5'b0, bytesel_q};
        default:   rd_val = '0;
      endcase
    end
  end

  assign host_fire     = bp.i_bp_valid && bp.o_bp_ready;
  assign resp_fire     = valid_q && bp.i_bp_ready;
  assign bp.o_bp_ready = (state_q != ST_RESP) && bp.i_bp_ready;
  assign bp.o_bp_data  = data_q;
  assign bp.o_bp_valid = valid_q;

  // ---------------------------------------------------------------------------
  // Command FSM: next state, register writes and response capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    chsel_d   = chsel_q;
    enmask_d  = enmask_q;
    bytesel_d = bytesel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    seed_we   = 1'b0;
    rd_addr   = addr_q;

    case (state_q)
      ST_IDLE: begin
        rd_addr = bp.i_bp_data[ADDR_W-1:0];
        if (host_fire) begin
          addr_d = bp.i_bp_data[ADDR_W-1:0];
          wr_d   = bp.i_bp_data[7];
          // Commands to BURST itself leave the armed count alone.
          if (bp.i_bp_data[ADDR_W-1:0] != A_BURST) begin
            cnt_d   = burst_q;
            burst_d = '0;
          end else begin
            cnt_d = '0;
          end
          if (bp.i_bp_data[7]) begin
            state_d = ST_WDATA;
          end else begin
            data_d  = rd_val;
            valid_d = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_WDATA: begin
        if (host_fire) begin
          data_d  = rd_val;   // value before the write; SEED/BURST read 0
          valid_d = 1'b1;
          state_d = ST_RESP;
          case (addr_q)
            A_BURST:   burst_d = bp.i_bp_data;
            A_CHSEL:   if (bp.i_bp_data < 8'(N_CH)) chsel_d = bp.i_bp_data[2:0];
            A_SEED:    seed_we = 1'b1;
            A_ENMASK:  enmask_d = bp.i_bp_data[N_CH-1:0];
            A_BYTESEL: bytesel_d = bp.i_bp_data[2:0];
            default:   ;
          endcase
        end
      end

      ST_RESP: begin
        if (resp_fire) begin
          if (cnt_q == 8'd0) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (wr_q) begin
              valid_d = 1'b0;
              state_d = ST_WDATA;
            end else begin
              data_d = rd_val;   // next burst byte, back-to-back
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      burst_q   <= '0;
      cnt_q     <= '0;
      chsel_q   <= '0;
      enmask_q  <= '1;
      bytesel_q <= 3'd7;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else if (i_cg) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      chsel_q   <= chsel_d;
      enmask_q  <= enmask_d;
      bytesel_q <= bytesel_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_xoroshiro_multi.sv
// -----------------------------------------------------------------------------
// tb_xoroshiro_multi
// Directed, table-driven bench for xoroshiro_multi (N_CH = 4): register
// reset values and writes, seeding and state readback, burst read with and
// without back-pressure, burst write, and reset during a pending write.
// -----------------------------------------------------------------------------
module tb_xoroshiro_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cg  = 1'b1;

  always #5 clk = ~clk;

  xoroshiro_multi_if bp();

  xoroshiro_multi #(.N_CH(4), .ADDR_W(7)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_cg  (cg),
    .bp    (bp)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bp.i_bp_data  = b;
    bp.i_bp_valid = 1'b1;
    while (!bp.o_bp_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bp.i_bp_valid = 1'b0;
  endtask

  task automatic recv(output logic [7:0] d);
    int n = 0;
    bp.i_bp_ready = 1'b1;
    while (!bp.o_bp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("recv_timeout", 32'(n), 32'd0);
    d = bp.o_bp_data;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    send({1'b0, a});
    recv(d);
    $display("[TB] rd  0x%02h -> 0x%02h", a, d);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] v, output logic [7:0] r);
    send({1'b1, a});
    send(v);
    recv(r);
    $display("[TB] wr  0x%02h <- 0x%02h, resp 0x%02h", a, v, r);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   d, d2, exp_b;
    logic [127:0] model;
    logic [63:0]  res;
    int           hs, cyc;

    tbl[0]  = '{0, 7'h06, 8'h00, 8'h07};   // BYTESEL reset
    tbl[1]  = '{0, 7'h05, 8'h00, 8'h0F};   // ENMASK reset
    tbl[2]  = '{0, 7'h01, 8'h00, 8'h00};   // CHSEL reset
    tbl[3]  = '{1, 7'h01, 8'h02, 8'h00};
    tbl[4]  = '{0, 7'h01, 8'h00, 8'h02};
    tbl[5]  = '{1, 7'h01, 8'h09, 8'h02};   // out of range, ignored
    tbl[6]  = '{0, 7'h01, 8'h00, 8'h02};
    tbl[7]  = '{1, 7'h01, 8'h03, 8'h02};
    tbl[8]  = '{0, 7'h01, 8'h00, 8'h03};
    tbl[9]  = '{1, 7'h01, 8'h00, 8'h03};
    tbl[10] = '{1, 7'h06, 8'h03, 8'h07};
    tbl[11] = '{0, 7'h06, 8'h00, 8'h03};
    tbl[12] = '{0, 7'h7F, 8'h00, 8'h00};   // unmapped
    tbl[13] = '{1, 7'h05, 8'hF0, 8'h0F};   // bits >= N_CH dropped
    tbl[14] = '{0, 7'h05, 8'h00, 8'h00};
    tbl[15] = '{0, 7'h00, 8'h00, 8'h00};   // BURST reads 0

    bp.i_bp_data  = 8'h00;
    bp.i_bp_valid = 1'b0;
    bp.i_bp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bp.o_bp_valid), 32'd0);
    check("reset_data",  32'(bp.o_bp_data),  32'd0);
    rst = 1'b0;

    // ---- register table ----
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata, d);
      else           rd(tbl[i].addr, d);
      check($sformatf("tbl[%0d] addr 0x%02h", i, tbl[i].addr), 32'(d), 32'(tbl[i].exp));
    end

    // ---- seed channel 0 (all channels disabled) ----
    model = '0;
    for (int i = 0; i < 16; i++) begin
      wr(7'h02, 8'(i + 1), d);
      check($sformatf("seed_resp[%0d]", i), 32'(d), 32'd0);
      model = {model[119:0], 8'(i + 1)};
    end
    for (int k = 0; k < 16; k++) begin
      rd(7'(8'h10 + k), d);
      check($sformatf("seed_state[%0d]", k), 32'(d), 32'(8'h10 - k));
    end
    res   = model[63:0] + model[127:64];
    exp_b = res[31:24];                    // BYTESEL = 3
    rd(7'h03, d);
    rd(7'h03, d2);
    check("result_byte3", 32'(d), 32'(exp_b));
    check("result_repeat", 32'(d2), 32'(exp_b));

    // ---- burst read, host always ready: 4 back-to-back bytes ----
    wr(7'h00, 8'h03, d);
    check("burst_wr_resp", 32'(d), 32'd0);
    send(8'h03);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bread_valid[%0d]", i), 32'(bp.o_bp_valid), 32'd1);
      check($sformatf("bread_data[%0d]", i),  32'(bp.o_bp_data),  32'(exp_b));
      $display("[TB] burst rd 0x03 beat %0d -> 0x%02h", i, bp.o_bp_data);
      @(posedge clk); #1;
    end
    check("bread_end_valid", 32'(bp.o_bp_valid), 32'd0);
    rd(7'h01, d);
    check("bread_idle_chsel", 32'(d), 32'd0);

    // ---- burst read with toggling host ready ----
    wr(7'h00, 8'h03, d);
    send(8'h10);
    hs  = 0;
    cyc = 0;
    while (hs < 4 && cyc < 60) begin
      bp.i_bp_ready = (cyc % 2) == 1;
      if (bp.o_bp_valid) begin
        check($sformatf("stall_data[%0d]", cyc), 32'(bp.o_bp_data), 32'h10);
        if (bp.i_bp_ready) begin
          $display("[TB] stalled burst beat %0d -> 0x%02h", hs, bp.o_bp_data);
          hs++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bp.i_bp_ready = 1'b1;
    check("stall_beats", 32'(hs), 32'd4);
    check("stall_end_valid", 32'(bp.o_bp_valid), 32'd0);
    @(posedge clk); #1;
    check("stall_no_extra", 32'(bp.o_bp_valid), 32'd0);

    // ---- burst write of 16 seed bytes ----
    wr(7'h00, 8'h0F, d);
    send(8'h82);
    for (int i = 0; i < 16; i++) begin
      send(8'hA0 + 8'(i * 3));
      recv(d);
      $display("[TB] burst wr 0x02 beat %0d <- 0x%02h, resp 0x%02h", i, 8'hA0 + 8'(i * 3), d);
      check($sformatf("bwrite_resp[%0d]", i), 32'(d), 32'd0);
      model = {model[119:0], 8'hA0 + 8'(i * 3)};
    end
    for (int k = 0; k < 16; k++) begin
      rd(7'(8'h10 + k), d);
      check($sformatf("bwrite_state[%0d]", k), 32'(d), 32'(model[8*k +: 8]));
    end

    // ---- reset while a write data byte is pending ----
    wr(7'h01, 8'h01, d);
    send(8'h81);
    bp.i_bp_data  = 8'h02;
    bp.i_bp_valid = 1'b1;
    rst           = 1'b1;
    @(posedge clk); #1;
    check("rst_wdata_valid", 32'(bp.o_bp_valid), 32'd0);
    rst           = 1'b0;
    bp.i_bp_valid = 1'b0;
    rd(7'h01, d);
    check("rst_chsel", 32'(d), 32'd0);
    rd(7'h05, d);
    check("rst_enmask", 32'(d), 32'h0F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
